// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port to single-port memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} arb_state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;
   typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick between the fetch port (A) and the data port (B).
module arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic  req_a,
   input  logic  req_b,
   input  port_t last_grant,
   output logic  grant_valid,
   output logic  conflict,
   output port_t grant
);

   always_comb begin
      grant_valid = req_a | req_b;
      conflict    = req_a & req_b;
      grant       = PORT_A;
      // On a conflict the port that did not win the previous conflict goes first.
      if (conflict) begin
         grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
      end else if (req_b) begin
         grant = PORT_B;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges the instruction-fetch port (A) and data port (B) onto one memory port.
// Handshake: a requester holds x_read/x_write with stable fields until x_resp; x_resp is a one-cycle pulse that mirrors m_resp while that port is being served, and the requester must drop its request in that cycle.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_read,
   input  logic [ADDR_W-1:0]   a_addr,
   output logic [DATA_W-1:0]   a_rdata,
   output logic                a_resp,
   input  logic                b_read,
   input  logic                b_write,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W-1:0]   b_wdata,
   input  logic [DATA_W/8-1:0] b_mbe,
   output logic [DATA_W-1:0]   b_rdata,
   output logic                b_resp,
   output logic                m_read,
   output logic                m_write,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_mbe,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_resp,
   output arb_state_t          dbg_state
);

   localparam int MBE_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   port_t             last_grant_q, last_grant_d;
   logic              m_read_q, m_read_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [MBE_W-1:0]  m_mbe_q, m_mbe_d;

   logic    grant_valid;
   logic    conflict;
   port_t   grant;
   mem_op_t grant_op;

   arb_rr_pick u_pick (
      .req_a       (a_read),
      .req_b       (b_read | b_write),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .conflict    (conflict),
      .grant       (grant)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      m_read_d     = m_read_q;
      m_write_d    = m_write_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_mbe_d      = m_mbe_q;
      grant_op     = OP_READ;
      a_resp       = 1'b0;
      b_resp       = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               if (conflict) begin
                  last_grant_d = grant;
               end
               if (grant == PORT_A) begin
                  state_d   = SERVE_A;
                  m_addr_d  = a_addr;
                  m_wdata_d = '0;
                  m_mbe_d   = '1;
                  grant_op  = OP_READ;
               end else begin
                  state_d   = SERVE_B;
                  m_addr_d  = b_addr;
                  m_wdata_d = b_wdata;
                  m_mbe_d   = b_mbe;
                  // A simultaneous read+write from B is resolved as a write.
                  grant_op  = b_write ? OP_WRITE : OP_READ;
               end
               m_read_d  = (grant_op == OP_READ);
               m_write_d = (grant_op == OP_WRITE);
            end
         end
         SERVE_A: begin
            if (m_resp) begin
               a_resp    = 1'b1;
               state_d   = IDLE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         SERVE_B: begin
            if (m_resp) begin
               b_resp    = 1'b1;
               state_d   = IDLE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= PORT_A;
         m_read_q     <= 1'b0;
         m_write_q    <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_mbe_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         m_read_q     <= m_read_d;
         m_write_q    <= m_write_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_mbe_q      <= m_mbe_d;
      end
   end

   assign m_read    = m_read_q;
   assign m_write   = m_write_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;
   assign m_mbe     = m_mbe_q;
   assign a_rdata   = m_rdata;
   assign b_rdata   = m_rdata;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic, checked against a transaction-level model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          a_read, b_read, b_write, m_resp;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] b_wdata, m_rdata;
   logic [BW-1:0] b_mbe;
   logic [DW-1:0] a_rdata, b_rdata, m_wdata;
   logic          a_resp, b_resp, m_read, m_write;
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_mbe;
   arb_state_t    dbg_state;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .a_read(a_read), .a_addr(a_addr), .a_rdata(a_rdata), .a_resp(a_resp),
      .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_mbe(b_mbe), .b_rdata(b_rdata), .b_resp(b_resp),
      .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_mbe(m_mbe), .m_rdata(m_rdata), .m_resp(m_resp),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int unsigned vec_cnt = 0;
   int unsigned err_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A granted transaction as the requester sees it.
   typedef struct {
      bit            is_b;
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] mbe;
   } txn_t;

   txn_t exp_q[$];
   bit   mdl_last_b = 1'b0;  // winner of the most recent conflict was B

   // Values applied at the next negative edge.
   logic          nx_a_read, nx_b_read, nx_b_write, nx_m_resp;
   logic [AW-1:0] nx_a_addr, nx_b_addr;
   logic [DW-1:0] nx_b_wdata, nx_m_rdata;
   logic [BW-1:0] nx_b_mbe;
   bit            auto_mode = 1'b0;
   bit            pend_a = 1'b0;
   bit            pend_b = 1'b0;

   // ---------------- driver tasks ----------------
   task automatic auto_drive();
      if (!pend_a && $urandom_range(0, 3) == 0) begin
         pend_a    = 1'b1;
         nx_a_addr = $urandom() & 32'h0000_0FFC;
      end else if (pend_a && $urandom_range(0, 5) == 0) begin
         nx_a_addr = $urandom();
      end
      nx_a_read = pend_a;

      if (!pend_b && $urandom_range(0, 3) == 0) begin
         pend_b = 1'b1;
         case ($urandom_range(0, 7))
            0:       begin nx_b_read = 1'b1; nx_b_write = 1'b1; end
            1, 2, 3: begin nx_b_read = 1'b1; nx_b_write = 1'b0; end
            default: begin nx_b_read = 1'b0; nx_b_write = 1'b1; end
         endcase
         nx_b_addr  = $urandom();
         nx_b_wdata = $urandom();
         nx_b_mbe   = BW'($urandom_range(0, 15));
      end else if (pend_b && $urandom_range(0, 5) == 0) begin
         nx_b_addr  = $urandom();
         nx_b_wdata = $urandom();
      end
      if (!pend_b) begin
         nx_b_read  = 1'b0;
         nx_b_write = 1'b0;
      end

      nx_m_rdata = $urandom();
      if (m_read || m_write) nx_m_resp = ($urandom_range(0, 2) == 0);
      else                   nx_m_resp = ($urandom_range(0, 7) == 0);
   endtask

   // One clock cycle: apply inputs, compare outputs, advance the model.
   task automatic cycle();
      txn_t t;
      bit   ra, rb, pick_b;
      @(negedge clk);
      if (auto_mode) auto_drive();
      a_read  = nx_a_read;  a_addr  = nx_a_addr;
      b_read  = nx_b_read;  b_write = nx_b_write;
      b_addr  = nx_b_addr;  b_wdata = nx_b_wdata; b_mbe = nx_b_mbe;
      m_resp  = nx_m_resp;  m_rdata = nx_m_rdata;
      #1;
      if (!rst) begin
         exp_q.delete();
         mdl_last_b = 1'b0;
         check_val("rst_m_read", m_read, 0);
         check_val("rst_m_write", m_write, 0);
         check_val("rst_a_resp", a_resp, 0);
         check_val("rst_b_resp", b_resp, 0);
      end else if (exp_q.size() != 0) begin
         t = exp_q[0];
         check_val("state_serve", dbg_state, t.is_b ? SERVE_B : SERVE_A);
         check_val("m_read", m_read, !t.is_wr);
         check_val("m_write", m_write, t.is_wr);
         check_val("m_addr", m_addr, t.addr);
         check_val("m_mbe", m_mbe, t.mbe);
         if (t.is_wr) check_val("m_wdata", m_wdata, t.wdata);
         check_val("a_resp", a_resp, !t.is_b && m_resp);
         check_val("b_resp", b_resp, t.is_b && m_resp);
         if (m_resp) begin
            if (t.is_b) check_val("b_rdata", b_rdata, m_rdata);
            else        check_val("a_rdata", a_rdata, m_rdata);
            void'(exp_q.pop_front());
         end
      end else begin
         check_val("state_idle", dbg_state, IDLE);
         check_val("idle_m_read", m_read, 0);
         check_val("idle_m_write", m_write, 0);
         check_val("idle_a_resp", a_resp, 0);
         check_val("idle_b_resp", b_resp, 0);
         ra = a_read;
         rb = b_read | b_write;
         if (ra || rb) begin
            if (ra && rb) begin
               pick_b     = !mdl_last_b;
               mdl_last_b = pick_b;
            end else begin
               pick_b = rb;
            end
            if (pick_b) begin
               t.is_b = 1'b1; t.is_wr = b_write; t.addr = b_addr;
               t.wdata = b_wdata; t.mbe = b_mbe;
            end else begin
               t.is_b = 1'b0; t.is_wr = 1'b0; t.addr = a_addr;
               t.wdata = '0; t.mbe = '1;
            end
            exp_q.push_back(t);
         end
      end
      if (auto_mode) begin
         if (a_resp) pend_a = 1'b0;
         if (b_resp) pend_b = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      nx_a_read = 1'b0; nx_b_read = 1'b0; nx_b_write = 1'b0; nx_m_resp = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      nx_a_addr = '0; nx_b_addr = '0; nx_b_wdata = '0; nx_b_mbe = '0; nx_m_rdata = '0;
      idle_inputs();
      repeat (2) cycle();
      rst = 1'b1;

      // Idle after reset: everything stays quiet.
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_val("rst_idle_m_addr", m_addr, 0);
         check_val("rst_idle_m_wdata", m_wdata, 0);
         check_val("rst_idle_m_mbe", m_mbe, 0);
      end

      // Single A read with a three-cycle memory latency.
      nx_a_read = 1'b1; nx_a_addr = 32'h60;
      cycle();
      cycle();
      check_val("a_rd_m_read_c1", m_read, 1);
      check_val("a_rd_m_addr", m_addr, 32'h60);
      check_val("a_rd_m_mbe", m_mbe, 4'hF);
      cycle();
      check_val("a_rd_m_read_c2", m_read, 1);
      nx_m_resp = 1'b1; nx_m_rdata = 32'h13;
      cycle();
      check_val("a_rd_resp", a_resp, 1);
      check_val("a_rd_rdata", a_rdata, 32'h13);
      idle_inputs();
      cycle();
      check_val("a_rd_m_read_drop", m_read, 0);

      // Conflict straight after reset: B wins, then A, then the next conflict goes to A.
      rst = 1'b0; cycle(); rst = 1'b1;
      nx_a_read = 1'b1; nx_a_addr = 32'h44;
      nx_b_write = 1'b1; nx_b_addr = 32'h100; nx_b_wdata = 32'hDEADBEEF; nx_b_mbe = 4'h3;
      cycle();
      cycle();
      check_val("cf_b_first_write", m_write, 1);
      check_val("cf_b_mbe", m_mbe, 4'h3);
      check_val("cf_b_wdata", m_wdata, 32'hDEADBEEF);
      nx_m_resp = 1'b1;
      cycle();
      check_val("cf_b_resp", b_resp, 1);
      nx_b_write = 1'b0; nx_m_resp = 1'b0;
      cycle();
      check_val("cf_bubble", m_read | m_write, 0);
      cycle();
      check_val("cf_a_second", m_read, 1);
      check_val("cf_a_addr", m_addr, 32'h44);
      nx_m_resp = 1'b1;
      cycle();
      nx_a_read = 1'b0; nx_m_resp = 1'b0;
      cycle();
      nx_a_read = 1'b1; nx_a_addr = 32'h48; nx_b_read = 1'b1; nx_b_addr = 32'h104;
      cycle();
      cycle();
      check_val("cf2_a_wins", m_addr, 32'h48);
      nx_m_resp = 1'b1;
      cycle();
      nx_a_read = 1'b0; nx_m_resp = 1'b0;
      cycle();
      cycle();
      check_val("cf2_b_after", m_addr, 32'h104);
      nx_m_resp = 1'b1;
      cycle();
      idle_inputs();
      cycle();

      // B read whose address changes mid-service.
      nx_b_read = 1'b1; nx_b_addr = 32'h180;
      cycle();
      cycle();
      nx_b_addr = 32'h200;
      cycle();
      check_val("latch_addr_1", m_addr, 32'h180);
      cycle();
      nx_m_resp = 1'b1;
      cycle();
      check_val("latch_addr_resp", m_addr, 32'h180);
      idle_inputs();
      cycle();

      // Asynchronous reset while serving A.
      nx_a_read = 1'b1; nx_a_addr = 32'h70;
      cycle();
      cycle();
      check_val("ar_m_read_before", m_read, 1);
      rst = 1'b0;
      #1;
      check_val("ar_m_read_drop", m_read, 0);
      check_val("ar_state_idle", dbg_state, IDLE);
      check_val("ar_no_resp", a_resp, 0);
      exp_q.delete();
      nx_a_read = 1'b0; nx_m_resp = 1'b1;
      cycle();
      rst = 1'b1;
      nx_m_resp = 1'b0;
      cycle();
      nx_a_read = 1'b1;
      cycle();
      cycle();
      nx_m_resp = 1'b1;
      cycle();
      check_val("ar_reissue_resp", a_resp, 1);
      idle_inputs();
      cycle();

      // Spurious m_resp in IDLE, then B read+write together resolved as a write.
      nx_m_resp = 1'b1;
      cycle();
      check_val("spur_a_resp", a_resp, 0);
      check_val("spur_b_resp", b_resp, 0);
      nx_m_resp = 1'b0;
      nx_b_read = 1'b1; nx_b_write = 1'b1; nx_b_addr = 32'h300; nx_b_wdata = 32'h1234_5678; nx_b_mbe = 4'hC;
      cycle();
      cycle();
      check_val("rw_m_write", m_write, 1);
      check_val("rw_m_read", m_read, 0);
      nx_m_resp = 1'b1;
      cycle();
      idle_inputs();
      cycle();

      // Random traffic.
      auto_mode = 1'b1;
      for (int i = 0; i < 3000; i++) cycle();
      auto_mode = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port to single-port memory arbiter sitting directly downstream of `one_hz_cpu`. It merges the instruction-fetch port (A: `pc`/`instr`/`imem_read`/`imem_resp`) and the data port (B: `mem_address`/`mem_rdata`/`mem_wdata`/`mem_read`/`mem_write`/`mem_byte_enable`/`mem_resp`) onto one read/write memory port with a resp handshake. Conflicts are resolved with round-robin arbitration, and each granted request is latched for its full duration.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; MBE width is DATA_W/8

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- a_read  in  1  port A read request, held until a_resp
- a_addr  in  ADDR_W  port A address
- a_rdata  out  DATA_W  port A read data, valid when a_resp=1
- a_resp  out  1  port A completion, one-cycle pulse
- b_read  in  1  port B read request
- b_write  in  1  port B write request
- b_addr  in  ADDR_W  port B address
- b_wdata  in  DATA_W  port B write data
- b_mbe  in  DATA_W/8  port B byte enables
- b_rdata  out  DATA_W  port B read data, valid when b_resp=1
- b_resp  out  1  port B completion, one-cycle pulse
- m_read  out  1  memory read
- m_write  out  1  memory write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_mbe  out  DATA_W/8  memory byte enables
- m_rdata  in  DATA_W  memory read data
- m_resp  in  1  memory completion

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B.
- IDLE:
  - Only a_read: latch request, go to SERVE_A.
  - Only b_read|b_write: latch, go to SERVE_B.
  - Both: grant the port not in `last_grant`, then update `last_grant`.
  - Neither: stay in IDLE.
- Latch at grant: addr, op (read/write), wdata, mbe.
  - m_* are driven only from latched registers, so requester changes mid-service have no effect.
- SERVE_x:
  - Drive m_read or m_write from the latched op.
  - Pass m_rdata combinationally to x_rdata.
  - On m_resp: x_resp=1 for that cycle, go to IDLE.
- Port A is always a read; m_mbe=all-ones for A.
- b_read and b_write both set: illegal. It is treated as a write.
- m_resp in IDLE is ignored and produces no x_resp.
- A requester's resp is never asserted in the cycle it is granted.

## Timing
- Reset values:
  - state=IDLE, last_grant=A (so B wins the first conflict).
  - m_read=m_write=0, m_addr=m_wdata=0, m_mbe=0.
  - a_resp=b_resp=0. a_rdata/b_rdata follow m_rdata but are don't-care.
- Latency:
  - Request seen in IDLE at cycle 0; m_read/m_write asserted cycle 1.
  - x_resp in the same cycle as m_resp (cycle ≥1).
  - The next grant is decided in the cycle after m_resp; the next m_* assertion follows one cycle later. Minimum 1 bubble between transactions.
- m_read/m_write stay high continuously from grant until the m_resp cycle inclusive, then drop.
- Requesters must hold their request until resp. The request is sampled again in IDLE after resp, so the requester must drop it in the resp cycle to avoid a re-issue.
- Async reset mid-transaction: m_* drop immediately, no resp is issued, and state goes to IDLE. The requester reissues after reset.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, SERVE_A, SERVE_B}
  - `port_t` enum {PORT_A, PORT_B}
  - `mem_op_t` enum {OP_READ, OP_WRITE}
  - default width localparams
- Single module. An optional combinational sub-module `arb_rr_pick` (2 requests + last_grant -> grant) is acceptable. No other hierarchy.

## Test plan
- Reset release, no requests -> all m_*, a_resp, b_resp stay 0 for 10 cycles.
- A read of 0x0000_0060, memory resp 3 cycles after m_read with data 0x0000_0013:
  - m_read high cycles 1-3, m_addr=0x60, m_mbe=0xF.
  - a_rdata=0x13 with a_resp at cycle 3.
- A read and B write (addr 0x100, wdata 0xDEADBEEF, mbe 0x3) asserted together right after reset:
  - B is served first with m_write, m_mbe=0x3.
  - Then A is served; 1 idle cycle between transactions.
  - The next simultaneous conflict grants A.
- B read granted, then b_addr changed to 0x200 mid-service -> m_addr stays at the original latched 0x180 until m_resp.
- rst pulled low during SERVE_A -> m_read drops asynchronously, a_resp never pulses, FSM is in IDLE after release.
- Spurious m_resp in IDLE -> no a_resp/b_resp. Also b_read=b_write=1 -> serviced as write (m_write=1, m_read=0).
